// File: rtl/mux_rr_feeder.sv
// Round-robin feeder for the 2:1 mux path: two 1-entry input buffers arbitrated
// onto a registered valid/ready operand stream with a wrapping beat counter.
module mux_rr_feeder #(
    parameter int DATA_WITH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_a_valid,
    input  logic [DATA_WITH-1:0] i_a_data,
    output logic                 o_a_ready,
    input  logic                 i_b_valid,
    input  logic [DATA_WITH-1:0] i_b_data,
    output logic                 o_b_ready,
    output logic [DATA_WITH-1:0] o_a,
    output logic [DATA_WITH-1:0] o_b,
    output logic                 o_sel,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic                 full_a_r;
    logic                 full_b_r;
    logic [DATA_WITH-1:0] buf_a_r;
    logic [DATA_WITH-1:0] buf_b_r;
    logic                 last_grant_r;
    logic [DATA_WITH-1:0] a_r;
    logic [DATA_WITH-1:0] b_r;
    logic                 sel_r;
    logic                 valid_r;
    logic [CNT_WIDTH-1:0] count_r;

    logic cap_a_s;
    logic cap_b_s;
    logic accept_s;
    logic load_s;
    logic winner_s;

    // Round-robin pick; 0 = A, 1 = B. Only meaningful when a buffer is full.
    function automatic logic pick_winner(input logic fa, input logic fb, input logic last);
        logic w;
        if (fa && fb) begin
            w = ~last;
        end else if (fa) begin
            w = 1'b0;
        end else begin
            w = 1'b1;
        end
        return w;
    endfunction

    // Handshake, load and arbitration decode.
    always_comb begin
        cap_a_s  = 1'b0;
        cap_b_s  = 1'b0;
        accept_s = 1'b0;
        load_s   = 1'b0;
        winner_s = 1'b0;
        cap_a_s  = i_a_valid && !full_a_r;
        cap_b_s  = i_b_valid && !full_b_r;
        accept_s = valid_r && i_ready;
        load_s   = (!valid_r || i_ready) && (full_a_r || full_b_r);
        winner_s = pick_winner(full_a_r, full_b_r, last_grant_r);
    end

    // Input buffers: capture only when empty, so a freed slot refills no earlier than next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_a_r <= 1'b0;
            full_b_r <= 1'b0;
            buf_a_r  <= '0;
            buf_b_r  <= '0;
        end else begin
            if (cap_a_s) begin
                full_a_r <= 1'b1;
                buf_a_r  <= i_a_data;
            end else if (load_s && !winner_s) begin
                full_a_r <= 1'b0;
            end else begin
                full_a_r <= full_a_r;
            end
            if (cap_b_s) begin
                full_b_r <= 1'b1;
                buf_b_r  <= i_b_data;
            end else if (load_s && winner_s) begin
                full_b_r <= 1'b0;
            end else begin
                full_b_r <= full_b_r;
            end
        end
    end

    // Output operand stage and arbitration history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_r          <= '0;
            b_r          <= '0;
            sel_r        <= 1'b0;
            valid_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (load_s) begin
            valid_r      <= 1'b1;
            sel_r        <= winner_s;
            last_grant_r <= winner_s;
            if (winner_s) begin
                b_r <= buf_b_r;
            end else begin
                a_r <= buf_a_r;
            end
        end else if (accept_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Accepted-beat counter, wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= '0;
        end else if (accept_s) begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign o_a_ready = !full_a_r;
    assign o_b_ready = !full_b_r;
    assign o_a       = a_r;
    assign o_b       = b_r;
    assign o_sel     = sel_r;
    assign o_valid   = valid_r;
    assign o_count   = count_r;

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Bench for mux_rr_feeder: directed vector table, hand-written corner sequences
// and a randomized run checked every cycle against a transaction-level model.
module tb_mux_rr_feeder;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_a_valid;
    logic [DW-1:0] i_a_data;
    logic          o_a_ready;
    logic          i_b_valid;
    logic [DW-1:0] i_b_data;
    logic          o_b_ready;
    logic [DW-1:0] o_a;
    logic [DW-1:0] o_b;
    logic          o_sel;
    logic          o_valid;
    logic          i_ready;
    logic [CW-1:0] o_count;

    mux_rr_feeder #(.DATA_WITH(DW), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_a_valid(i_a_valid), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
        .i_b_valid(i_b_valid), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
        .o_a(o_a), .o_b(o_b), .o_sel(o_sel), .o_valid(o_valid),
        .i_ready(i_ready), .o_count(o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int misses  = 0;

    // Reference model: per-channel slots (0 = A, 1 = B) plus one output beat.
    logic          m_full [2];
    logic [DW-1:0] m_word [2];
    logic [DW-1:0] m_opnd [2];
    int            m_last;
    int            m_sel;
    logic          m_valid;
    int            m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_full[c] = 1'b0;
            m_word[c] = '0;
            m_opnd[c] = '0;
        end
        m_last  = 1;
        m_sel   = 0;
        m_valid = 1'b0;
        m_count = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_advance();
        logic in_v [2];
        logic [DW-1:0] in_d [2];
        logic was_full [2];
        int   w;
        bit   out_free;
        in_v[0] = i_a_valid; in_d[0] = i_a_data;
        in_v[1] = i_b_valid; in_d[1] = i_b_data;
        was_full = m_full;
        out_free = !m_valid || i_ready;
        if (m_valid && i_ready) m_count = (m_count + 1) % (1 << CW);
        if (out_free && (was_full[0] || was_full[1])) begin
            if (was_full[0] && was_full[1]) w = 1 - m_last;
            else w = was_full[0] ? 0 : 1;
            m_opnd[w] = m_word[w];
            m_full[w] = 1'b0;
            m_sel     = w;
            m_last    = w;
            m_valid   = 1'b1;
        end else if (m_valid && i_ready) begin
            m_valid = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            if (in_v[c] && !was_full[c]) begin
                m_full[c] = 1'b1;
                m_word[c] = in_d[c];
            end
        end
    endtask

    task automatic compare_model();
        chk("valid",   {31'd0, o_valid},   {31'd0, m_valid});
        chk("a_ready", {31'd0, o_a_ready}, {31'd0, !m_full[0]});
        chk("b_ready", {31'd0, o_b_ready}, {31'd0, !m_full[1]});
        chk("count",   32'(o_count),       32'(m_count));
        chk("o_a",     32'(o_a),           32'(m_opnd[0]));
        chk("o_b",     32'(o_b),           32'(m_opnd[1]));
        chk("sel",     {31'd0, o_sel},     32'(m_sel));
    endtask

    task automatic step();
        model_advance();
        @(posedge i_clk);
        #1;
        compare_model();
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge.
    task automatic do_reset();
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        compare_model();
        i_a_valid = 1'b0; i_b_valid = 1'b0; i_ready = 1'b0;
        i_a_data = '0; i_b_data = '0;
        @(posedge i_clk);
        #1;
        compare_model();
        i_rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic          rst;
        logic          av;
        logic [DW-1:0] ad;
        logic          bv;
        logic [DW-1:0] bd;
        logic          rdy;
        logic          ev;
        logic          es;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic          ear;
        logic          ebr;
        logic [CW-1:0] ec;
    } vec_t;

    vec_t tbl [11];

    int na, nb, nbeat, exp_sel;
    logic ra, rb;

    initial begin
        //          rst   av    ad     bv    bd     rdy  | ev   es    ea     eb     ear   ebr   ec
        tbl[0]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 4'd0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b1, 4'd0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b1, 4'd1};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 4'd0};
        tbl[4]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'd0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b1, 4'd1};
        tbl[7]  = '{1'b0, 1'b1, 8'h33, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 4'd2};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33, 8'h22, 1'b1, 1'b0, 4'd2};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b1, 4'd3};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 8'h44, 1'b1, 1'b1, 4'd4};

        i_rst_n = 1'b0;
        i_a_valid = 1'b0; i_b_valid = 1'b0; i_ready = 1'b0;
        i_a_data = '0; i_b_data = '0;
        model_reset();
        @(posedge i_clk);
        #1;
        do_reset();

        // Directed table: single channel, reset, contention and round-robin repeat.
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) begin
                do_reset();
            end else begin
                i_a_valid = tbl[i].av; i_a_data = tbl[i].ad;
                i_b_valid = tbl[i].bv; i_b_data = tbl[i].bd;
                i_ready   = tbl[i].rdy;
                step();
            end
            chk($sformatf("tbl%0d_valid", i),   {31'd0, o_valid},   {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_sel", i),     {31'd0, o_sel},     {31'd0, tbl[i].es});
            chk($sformatf("tbl%0d_a", i),       32'(o_a),           32'(tbl[i].ea));
            chk($sformatf("tbl%0d_b", i),       32'(o_b),           32'(tbl[i].eb));
            chk($sformatf("tbl%0d_a_ready", i), {31'd0, o_a_ready}, {31'd0, tbl[i].ear});
            chk($sformatf("tbl%0d_b_ready", i), {31'd0, o_b_ready}, {31'd0, tbl[i].ebr});
            chk($sformatf("tbl%0d_count", i),   32'(o_count),       32'(tbl[i].ec));
        end

        // Backpressure: B beat stalls with A buffered behind it.
        do_reset();
        i_ready = 1'b0;
        i_b_valid = 1'b1; i_b_data = 8'h22;
        step();
        i_b_valid = 1'b0;
        i_a_valid = 1'b1; i_a_data = 8'h55;
        step();
        i_a_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", {31'd0, o_valid}, 32'd1);
            chk("stall_sel", {31'd0, o_sel}, 32'd1);
            chk("stall_b", 32'(o_b), 32'h22);
            chk("stall_a_ready", {31'd0, o_a_ready}, 32'd0);
        end
        i_ready = 1'b1;
        step();
        chk("bp_count", 32'(o_count), 32'd1);
        chk("bp_sel", {31'd0, o_sel}, 32'd0);
        chk("bp_a", 32'(o_a), 32'h55);

        // Fill both buffers behind a stalled beat, then reset mid-stream.
        i_ready = 1'b0;
        i_a_valid = 1'b1; i_a_data = 8'h66;
        i_b_valid = 1'b1; i_b_data = 8'h77;
        step();
        step();
        chk("full_a_ready", {31'd0, o_a_ready}, 32'd0);
        chk("full_b_ready", {31'd0, o_b_ready}, 32'd0);
        chk("full_valid", {31'd0, o_valid}, 32'd1);
        do_reset();
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_a", 32'(o_a), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ready", {30'd0, o_a_ready, o_b_ready}, 32'd3);

        // Streaming with counter wrap: both channels always offering, i_ready high.
        na = 0; nb = 0; nbeat = 0; exp_sel = 0;
        i_ready = 1'b1;
        i_a_valid = 1'b1; i_b_valid = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            i_a_data = 8'(8'h10 + na);
            i_b_data = 8'(8'h80 + nb);
            ra = o_a_ready;
            rb = o_b_ready;
            step();
            if (ra) na++;
            if (rb) nb++;
            if (k >= 2) begin
                chk("stream_valid", {31'd0, o_valid}, 32'd1);
                chk("stream_sel", {31'd0, o_sel}, 32'(exp_sel));
                if (exp_sel == 0) chk("stream_a", 32'(o_a), 32'(8'h10 + nbeat / 2));
                else chk("stream_b", 32'(o_b), 32'(8'h80 + nbeat / 2));
                exp_sel = 1 - exp_sel;
                nbeat++;
            end
            if (k == 17) chk("wrap_15", 32'(o_count), 32'd15);
            if (k == 18) chk("wrap_0", 32'(o_count), 32'd0);
            if (k == 19) chk("wrap_1", 32'(o_count), 32'd1);
        end
        chk("stream_count", 32'(o_count), 32'(20 % 16));
        i_a_valid = 1'b0; i_b_valid = 1'b0;

        // Randomized traffic against the model, with occasional async reset.
        for (int k = 0; k < 1500; k++) begin
            i_a_valid = 1'($urandom_range(0, 1));
            i_b_valid = 1'($urandom_range(0, 1));
            i_a_data  = 8'($urandom);
            i_b_data  = 8'($urandom);
            i_ready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/mux_rr_feeder.md
Name: mux_rr_feeder

Overview:
- Upstream feeder stage for the 2:1 mux path. Drives the mux's `a`, `b` and `sel` operands.
- Accepts two independent valid/ready input streams (channel A, channel B) and holds each in a 1-entry buffer.
- Arbitrates round-robin between them and presents registered operands plus a select to the downstream mux master.
- The output side is a valid/ready stream. Each output beat carries exactly one granted word, picked by `o_sel`.

Parameters:
- DATA_WITH, 8, width of each data word on A, B and the mux operands.
- CNT_WIDTH, 8, width of the completed-transfer counter.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_a_valid  input  1  channel A word valid.
- i_a_data  input  DATA_WITH  channel A word.
- o_a_ready  output  1  channel A buffer empty, can accept.
- i_b_valid  input  1  channel B word valid.
- i_b_data  input  DATA_WITH  channel B word.
- o_b_ready  output  1  channel B buffer empty, can accept.
- o_a  output  DATA_WITH  registered mux operand a.
- o_b  output  DATA_WITH  registered mux operand b.
- o_sel  output  1  mux select: 0 = o_a granted, 1 = o_b granted.
- o_valid  output  1  operands and select valid.
- i_ready  input  1  downstream accepts the current beat.
- o_count  output  CNT_WIDTH  number of output beats accepted, wrapping.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - o_a = 0, o_b = 0, o_sel = 0, o_valid = 0, o_count = 0.
  - Both buffers empty, so o_a_ready = o_b_ready = 1.
  - last_grant = B, so A wins the first contention.
  - Buffered and in-flight words are discarded.
- Input buffers:
  - o_a_ready = !full_a and o_b_ready = !full_b, both purely from registers.
  - Handshake on valid && ready: data is captured and full is set at that edge.
  - A buffer freed by a grant is not refillable in the same cycle; its ready rises the next cycle.
  - Each channel therefore sustains at most one word per 2 cycles.
- Load condition: load = (!o_valid || i_ready) && (full_a || full_b).
- Winner selection:
  - Only full_a → A. Only full_b → B.
  - Both full → the channel != last_grant.
- On load:
  - o_valid <= 1, o_sel <= winner, last_grant <= winner.
  - The winner's operand register (o_a for A, o_b for B) takes its buffer contents; the other operand register holds its previous value.
  - The winner's full flag is cleared.
- When o_valid && i_ready and no load occurs: o_valid <= 0.
- Stall: while o_valid && !i_ready, o_a, o_b, o_sel and o_valid are stable, and the buffers keep their data.
- Counter: o_count increments by 1 on every o_valid && i_ready and wraps from 2^CNT_WIDTH-1 to 0.
- Latency and throughput:
  - A word accepted at edge N appears with o_valid = 1 after edge N+1 when the output stage is free.
  - With both channels continuously offering and i_ready = 1, the output sustains 1 beat/cycle alternating A, B, A, B.
- Simultaneous events:
  - In the same cycle, an input capture on one channel, a grant of the other, and a downstream accept are all legal and independent.
  - A word captured at edge N is not eligible for the load at edge N.
- No combinational path from any input to any output.

Test Plan:
- Reset check: assert i_rst_n=0 mid-stream with both buffers full and o_valid=1 → immediately o_valid=0, o_a=o_b=0, o_sel=0, o_count=0, o_a_ready=o_b_ready=1.
- Single channel: i_a_data=0x3C accepted at edge 1, i_ready=1 → after edge 2 o_valid=1, o_sel=0, o_a=0x3C, o_b=0x00. After edge 3 o_count=1 and o_a_ready=1.
- Contention: A=0x11 and B=0x22 accepted on the same edge, i_ready=1 → beats (sel=0, o_a=0x11) then (sel=1, o_b=0x22) on consecutive cycles. A further A=0x33 and B=0x44 pair yields A first again, because last_grant=B.
- Backpressure: o_valid=1, sel=1, o_b=0x22, i_ready=0 for 5 cycles while A=0x55 is buffered → outputs stable and o_a_ready=0. When i_ready=1: 0x22 is accepted, then the next cycle sel=0, o_a=0x55.
- Streaming: both channels always valid with incrementing data, i_ready=1 for 20 cycles → o_valid high every cycle after the first output, strict A/B alternation, no word lost or duplicated, o_count=20.
- Counter wrap: CNT_WIDTH=4, 17 accepted beats → o_count sequence reaches 15, then 0, then 1.
